// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM transaction controller.
package atm_pkg;

    localparam int unsigned ATM_PIN_W   = 14;
    localparam int unsigned ATM_AMT_W   = 15;
    localparam int unsigned ATM_MAX_AMT = 20000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CHK = 2'd1,
        ST_WAIT_AMT = 2'd2,
        ST_DONE     = 2'd3
    } atm_state_e;

    // Amount is acceptable when non-zero and not above the per-withdrawal limit.
    function automatic logic amt_in_range(input logic [31:0] amt, input int unsigned max_amt);
        return (amt != 32'd0) && (amt <= 32'(max_amt));
    endfunction

endpackage

// File: rtl/atm_system.sv
// ATM transaction controller: PIN latch, PIN confirm, amount check, dispense/issue decision.
module atm_system
    import atm_pkg::*;
#(
    parameter int unsigned PIN_W   = ATM_PIN_W,
    parameter int unsigned AMT_W   = ATM_AMT_W,
    parameter int unsigned MAX_AMT = ATM_MAX_AMT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pin_ent,
    input  logic             pin_chk,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] pin_cnfm,
    input  logic [AMT_W-1:0] amt,
    input  logic             amt_ent,
    output logic             disp,
    output logic             issue
);

    atm_state_e       r_state;
    atm_state_e       w_next_state;
    logic [PIN_W-1:0] r_pin_reg;
    logic [PIN_W-1:0] w_next_pin_reg;
    logic             r_disp;
    logic             w_next_disp;
    logic             r_issue;
    logic             w_next_issue;
    logic             w_amt_ok;

    assign w_amt_ok = amt_in_range(32'(amt), MAX_AMT);

    // State, latched PIN and decision outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pin_reg <= '0;
            r_disp    <= 1'b0;
            r_issue   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pin_reg <= w_next_pin_reg;
            r_disp    <= w_next_disp;
            r_issue   <= w_next_issue;
        end
    end

    // Next-state and next-output decode; a PIN entry restarts from any state.
    always_comb begin
        w_next_state   = r_state;
        w_next_pin_reg = r_pin_reg;
        w_next_disp    = r_disp;
        w_next_issue   = r_issue;

        if (pin_ent) begin
            w_next_pin_reg = pin;
            w_next_disp    = 1'b0;
            w_next_issue   = 1'b0;
            w_next_state   = ST_WAIT_CHK;
        end else begin
            case (r_state)
                ST_WAIT_CHK: begin
                    if (pin_chk) begin
                        if (pin_cnfm == r_pin_reg) begin
                            w_next_state = ST_WAIT_AMT;
                        end else begin
                            w_next_issue   = 1'b1;
                            w_next_pin_reg = '0;
                            w_next_state   = ST_DONE;
                        end
                    end
                end
                ST_WAIT_AMT: begin
                    if (amt_ent) begin
                        w_next_disp    = w_amt_ok;
                        w_next_issue   = !w_amt_ok;
                        w_next_pin_reg = '0;
                        w_next_state   = ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE wait for the next PIN entry.
                end
            endcase
        end
    end

    assign disp  = r_disp;
    assign issue = r_issue;

endmodule

// File: tb/tb_atm_system.sv
// Directed self-checking bench for atm_system.
module tb_atm_system;

    logic        clk;
    logic        rst;
    logic        pin_ent;
    logic        pin_chk;
    logic [13:0] pin;
    logic [13:0] pin_cnfm;
    logic [14:0] amt;
    logic        amt_ent;
    logic        disp;
    logic        issue;

    int n_vec;
    int n_err;

    atm_system dut (
        .clk      (clk),
        .rst      (rst),
        .pin_ent  (pin_ent),
        .pin_chk  (pin_chk),
        .pin      (pin),
        .pin_cnfm (pin_cnfm),
        .amt      (amt),
        .amt_ent  (amt_ent),
        .disp     (disp),
        .issue    (issue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then move to 1 time unit after the sampling edge.
    task automatic cyc(input logic pe, input logic pc, input logic ae,
                       input int p, input int c, input int a);
        pin_ent  = pe;
        pin_chk  = pc;
        amt_ent  = ae;
        pin      = 14'(p);
        pin_cnfm = 14'(c);
        amt      = 15'(a);
        @(posedge clk);
        #1;
        pin_ent = 1'b0;
        pin_chk = 1'b0;
        amt_ent = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic check(input string tag, input logic exp_disp, input logic exp_issue);
        n_vec++;
        assert ({disp, issue} === {exp_disp, exp_issue})
        else begin
            n_err++;
            $error("FAIL %s: disp/issue=%b%b expected %b%b", tag, disp, issue, exp_disp, exp_issue);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        pin_ent  = 1'b0;
        pin_chk  = 1'b0;
        amt_ent  = 1'b0;
        pin      = '0;
        pin_cnfm = '0;
        amt      = '0;

        idle();
        idle();
        rst = 1'b0;
        check("reset", 1'b0, 1'b0);

        // IDLE ignores pin_chk (cnfm 0 would match cleared pin_reg) and amt_ent
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);      check("idle_chk_ignored", 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 5);      check("idle_amt_ignored", 1'b0, 1'b0);

        // Correct PIN, valid amount
        cyc(1'b1, 1'b0, 1'b0, 8434, 0, 0);   check("t1_ent", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 8434, 0);   check("t1_chk", 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 15000);  check("t1_disp", 1'b1, 1'b0);
        idle();                               check("t1_hold1", 1'b1, 1'b0);
        idle();                               check("t1_hold2", 1'b1, 1'b0);

        // Back-to-back: new pin_ent clears disp; wrong PIN
        cyc(1'b1, 1'b0, 1'b0, 8434, 0, 0);   check("t2_ent_clears", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1234, 0);   check("t2_wrong_pin", 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 15000);  check("t2_amt_after_fail", 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 0, 8434, 0);   check("t2_chk_in_done", 1'b0, 1'b1);

        // Over limit, at limit, zero, max code
        cyc(1'b1, 1'b0, 1'b0, 5587, 0, 0);   check("t3a_ent", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 5587, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 20001);  check("t3a_over", 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 5587, 0, 0);   check("t3b_ent_clears", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 5587, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 20000);  check("t3b_at_limit", 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5587, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0, 5587, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);      check("t3c_zero", 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16383, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0, 16383, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 32767);  check("t3d_max_code", 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1);      check("t3e_amt_one", 1'b1, 1'b0);

        // Reset mid-transaction in WAIT_AMT
        cyc(1'b1, 1'b0, 1'b0, 5587, 0, 0);   check("t4_ent", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 5587, 0);
        rst = 1'b1;
        idle();
        rst = 1'b0;                           check("t4_reset", 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 100);    check("t4_amt_after_rst", 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 77, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0, 77, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 100);    check("t4_fresh", 1'b1, 1'b0);

        // Priority: pin_ent with pin_chk re-latches only; amt_ent ignored in WAIT_CHK
        cyc(1'b1, 1'b0, 1'b0, 100, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 200, 100, 0);  check("t5_ent_and_chk", 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 50);     check("t5_amt_in_waitchk", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 200, 0);    check("t5_chk_relatched", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 999, 0);    check("t5_chk_in_waitamt", 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 50);     check("t5_disp", 1'b1, 1'b0);

        // Last of repeated pin_ent wins
        cyc(1'b1, 1'b0, 1'b0, 300, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 400, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0, 300, 0);    check("t6_stale_pin", 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/atm_system.md
# atm_system

Transaction controller for a simple ATM front end. It latches an entered PIN, compares it with a confirmation PIN, then accepts a withdrawal amount and decides between dispensing cash (`disp`) and flagging an error (`issue`). It sits between the keypad/user-input logic and the cash-dispenser/error-reporting logic. All inputs are single-cycle-sampled strobes with data.

## Interface
- `PIN_W`, default 14: PIN width in bits.
- `AMT_W`, default 15: amount width in bits.
- `MAX_AMT`, default 20000: largest amount allowed per withdrawal; unsigned, inclusive.

One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `pin_ent`  in  1  PIN-entry strobe; `pin` is sampled while high.
- `pin_chk`  in  1  PIN-confirm strobe; `pin_cnfm` is sampled while high.
- `pin`  in  PIN_W  entered PIN.
- `pin_cnfm`  in  PIN_W  confirmation PIN.
- `amt`  in  AMT_W  requested amount, unsigned.
- `amt_ent`  in  1  amount strobe; `amt` is sampled while high.
- `disp`  out  1  withdrawal approved; cash dispensed.
- `issue`  out  1  transaction failed: PIN mismatch or amount out of range.

## Operation
- FSM states are IDLE, WAIT_CHK, WAIT_AMT and DONE.
- **Restart on `pin_ent`** (any state; highest priority over `pin_chk` and `amt_ent` in the same cycle):
  - store `pin` in `pin_reg`;
  - clear `disp` and `issue`;
  - go to WAIT_CHK.
  - Repeated `pin_ent` cycles re-latch, so the last sampled value wins.
- **WAIT_CHK, `pin_chk`=1, `pin_ent`=0:**
  - if `pin_cnfm == pin_reg`, go to WAIT_AMT;
  - otherwise set `issue`=1, clear `pin_reg`, go to DONE.
  - `amt_ent` is ignored in this state.
- **WAIT_AMT, `amt_ent`=1:**
  - if 1 ≤ `amt` ≤ MAX_AMT, set `disp`=1;
  - otherwise (0, or above MAX_AMT) set `issue`=1.
  - In both cases clear `pin_reg` and go to DONE.
  - `pin_chk` is ignored in this state.
- **DONE:** `disp`/`issue` hold their value; every strobe except `pin_ent` is ignored.
- **IDLE:** `pin_chk` and `amt_ent` are ignored.
- `disp` and `issue` are never high together.
- Strobes with no data change are legal; every strobe is evaluated each cycle it is high.

## Timing
- Reset (synchronous, any state, including mid-transaction) sets:
  - state to IDLE;
  - `pin_reg` to 0;
  - `disp` and `issue` to 0.
- All outputs are registered. `disp`/`issue` change on the edge that samples the deciding strobe, so they are visible 1 cycle after the strobe is sampled.
- `disp`/`issue` are cleared on the edge that samples `pin_ent`.
- There is no back-pressure, and no minimum gap between phases.
  - `pin_ent` followed by `pin_chk` in the very next cycle is legal.
  - `pin_chk` and `amt_ent` in consecutive cycles complete in 2 cycles.
- Minimum transaction length is 3 strobe cycles.

## Structure
- Shared package `atm_pkg` holds:
  - the state enum;
  - default width constants (PIN_W = 14, AMT_W = 15);
  - MAX_AMT default 20000.
- Single flat module; no sub-module needed.
  - The amount range check may be a small combinational function in the package.

## Test plan
- Correct PIN, valid amount: `pin_ent` with 8434, then `pin_chk` with 8434, then `amt_ent` with 15000 → `disp`=1, `issue`=0, held through idle cycles.
- Wrong PIN: 8434 entered, 1234 confirmed → `issue`=1 one cycle after `pin_chk`; a later `amt_ent` with 15000 leaves `disp`=0.
- Over limit: 5587/5587, then amount 20001 → `issue`=1; repeat with amount 20000 → `disp`=1; amount 0 → `issue`=1.
- Back-to-back transactions: after `disp`=1, a new `pin_ent` clears `disp` the same edge; the second transaction decides independently.
- Reset mid-transaction: `rst` in WAIT_AMT, then `amt_ent` with 100 → no output; a fresh sequence works.
- Priority:
  - `pin_ent` and `pin_chk` in the same cycle → re-latch only, no compare;
  - `amt_ent` while in WAIT_CHK → ignored.
